// File: rtl/firebird7_in_gate2_edt_channel_out_pipe.sv
// firebird7_in_gate2_edt_channel_out_pipe
//
// Output-channel retiming pipeline for the gate2 EDT logic. It sits directly
// after the 2x1 channel output mux. On each shift it masks individual channels
// and moves the data through DEPTH register stages toward the scan-out pads.
// A saturating fill counter records how many shifts have entered since the
// last EDT update, so the tester side knows when the pipe holds fresh data.
//
// Parameters
//   WIDTH        number of output channels (1..16), equal to the upstream mux width
//   DEPTH        number of pipeline stages (1..8)
//
// Ports
//   edt_clock    EDT shift clock; all state changes on its rising edge
//   edt_reset_n  asynchronous active-low reset
//   pipe_in      channel bits from the upstream mux
//   shift_en     pipeline advances only while this is high
//   edt_update   one-cycle pulse at pattern-load start; clears the fill counter
//   edt_bypass   1 = pipe_out taken combinationally from pipe_in
//   chan_mask    1 = force that channel to 0 as it enters stage 0
//   pipe_out     retimed channel bits to the scan-out pads
//   pipe_primed  high once DEPTH shifts have entered since the last update
//   fill_cnt     shifts since the last update, saturating at DEPTH

module firebird7_in_gate2_edt_channel_out_pipe #(
   parameter  int WIDTH = 2,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             edt_clock,
   input  logic             edt_reset_n,
   input  logic [WIDTH-1:0] pipe_in,
   input  logic             shift_en,
   input  logic             edt_update,
   input  logic             edt_bypass,
   input  logic [WIDTH-1:0] chan_mask,
   output logic [WIDTH-1:0] pipe_out,
   output logic             pipe_primed,
   output logic [CW-1:0]    fill_cnt
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] stage_r [DEPTH];
   logic [CW-1:0]    fill_cnt_r;

   // Data stages: the mask is applied only as data enters stage 0, so a mask
   // change never alters data that is already in flight.
   always_ff @(posedge edt_clock or negedge edt_reset_n) begin
      if (!edt_reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_r[k] <= {WIDTH{1'b0}};
         end
      end else if (shift_en) begin
         stage_r[0] <= pipe_in & ~chan_mask;
         for (int k = 1; k < DEPTH; k++) begin
            stage_r[k] <= stage_r[k-1];
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_r[k] <= stage_r[k];
         end
      end
   end

   // Fill counter: an update clears it even when the data shifts in the same
   // cycle, so that shift is not counted. Otherwise it counts shifts and
   // saturates at DEPTH.
   always_ff @(posedge edt_clock or negedge edt_reset_n) begin
      if (!edt_reset_n) begin
         fill_cnt_r <= {CW{1'b0}};
      end else if (edt_update) begin
         fill_cnt_r <= {CW{1'b0}};
      end else if (shift_en && (fill_cnt_r < FULL_CNT)) begin
         fill_cnt_r <= fill_cnt_r + CW'(1);
      end else begin
         fill_cnt_r <= fill_cnt_r;
      end
   end

   // Output mux: bypass is an unmasked combinational path and does not stop
   // the stages from shifting underneath it.
   always_comb begin
      pipe_out = {WIDTH{1'b0}};
      if (edt_bypass) begin
         pipe_out = pipe_in;
      end else begin
         pipe_out = stage_r[DEPTH-1];
      end
   end

   assign fill_cnt    = fill_cnt_r;
   assign pipe_primed = (fill_cnt_r == FULL_CNT);

endmodule

// File: tb/tb_firebird7_in_gate2_edt_channel_out_pipe.sv
// Self-checking bench for firebird7_in_gate2_edt_channel_out_pipe. Two
// instances (DEPTH=2 and DEPTH=4) share all inputs. The reference model keeps
// a plain history of the masked words shifted in since reset, plus a shift
// count since the last update for each depth.

module tb_firebird7_in_gate2_edt_channel_out_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] pipe_in;
   logic       shift_en;
   logic       edt_update;
   logic       edt_bypass;
   logic [1:0] chan_mask;

   logic [1:0] out2, out4;
   logic       primed2, primed4;
   logic [1:0] cnt2;
   logic [2:0] cnt4;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [1:0] hist[$];
   int         mcnt2, mcnt4;

   always #5 clk = ~clk;

   firebird7_in_gate2_edt_channel_out_pipe #(.WIDTH(2), .DEPTH(2)) dut2 (
      .edt_clock(clk), .edt_reset_n(rst_n), .pipe_in(pipe_in),
      .shift_en(shift_en), .edt_update(edt_update), .edt_bypass(edt_bypass),
      .chan_mask(chan_mask), .pipe_out(out2), .pipe_primed(primed2),
      .fill_cnt(cnt2));

   firebird7_in_gate2_edt_channel_out_pipe #(.WIDTH(2), .DEPTH(4)) dut4 (
      .edt_clock(clk), .edt_reset_n(rst_n), .pipe_in(pipe_in),
      .shift_en(shift_en), .edt_update(edt_update), .edt_bypass(edt_bypass),
      .chan_mask(chan_mask), .pipe_out(out4), .pipe_primed(primed4),
      .fill_cnt(cnt4));

   function automatic logic [1:0] exp_out(int d);
      if (edt_bypass) return pipe_in;
      if (hist.size() >= d) return hist[hist.size() - d];
      return 2'b00;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      mcnt2 = 0;
      mcnt4 = 0;
   endtask

   task automatic check_model();
      chk("out_d2",    32'(out2),    32'(exp_out(2)));
      chk("cnt_d2",    32'(cnt2),    32'(mcnt2));
      chk("primed_d2", 32'(primed2), 32'(mcnt2 == 2));
      chk("out_d4",    32'(out4),    32'(exp_out(4)));
      chk("cnt_d4",    32'(cnt4),    32'(mcnt4));
      chk("primed_d4", 32'(primed4), 32'(mcnt4 == 4));
   endtask

   // One clock edge: update the model from the inputs seen at the edge,
   // then compare just after it.
   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (shift_en) begin
            hist.push_back(pipe_in & ~chan_mask);
            if (hist.size() > 8) void'(hist.pop_front());
         end
         if (edt_update) begin
            mcnt2 = 0;
            mcnt4 = 0;
         end else if (shift_en) begin
            if (mcnt2 < 2) mcnt2++;
            if (mcnt4 < 4) mcnt4++;
         end
      end
      #1;
      check_model();
   endtask

   initial begin
      // reset held with live inputs
      rst_n = 1'b0; pipe_in = 2'b11; shift_en = 1'b1;
      edt_update = 1'b0; edt_bypass = 1'b0; chan_mask = 2'b00;
      model_reset();
      #1;
      check_model();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_out", 32'(out2), 32'h0);
      end
      rst_n = 1'b1;
      step();
      step();
      chk("post_rst_out", 32'(out2), 32'h3);
      chk("post_rst_primed", 32'(primed2), 32'h1);

      // latency and hold
      pipe_in = 2'b01; step();
      pipe_in = 2'b10; step();
      chk("lat_01", 32'(out2), 32'h1);
      pipe_in = 2'b11; step();
      chk("lat_10", 32'(out2), 32'h2);
      shift_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_10", 32'(out2), 32'h2);
      end
      shift_en = 1'b1; step();
      chk("lat_11", 32'(out2), 32'h3);

      // masking
      chan_mask = 2'b10; pipe_in = 2'b11;
      step(); step();
      chk("mask_01", 32'(out2), 32'h1);
      chan_mask = 2'b00;
      step();
      chk("unmask_a", 32'(out2), 32'h1);
      step();
      chk("unmask_b", 32'(out2), 32'h3);

      // fill counter
      edt_update = 1'b1; step();
      chk("upd_cnt", 32'(cnt2), 32'h0);
      edt_update = 1'b0;
      step();
      chk("fill1", 32'(cnt2), 32'h1);
      chk("fill1_primed", 32'(primed2), 32'h0);
      step();
      chk("fill2", 32'(cnt2), 32'h2);
      chk("fill2_primed", 32'(primed2), 32'h1);
      for (int i = 0; i < 5; i++) step();
      chk("fill_sat", 32'(cnt2), 32'h2);

      // bypass with shifting stopped
      shift_en = 1'b0; edt_bypass = 1'b1;
      pipe_in = 2'b00; #1; check_model();
      pipe_in = 2'b11; #1; check_model();
      pipe_in = 2'b01; #1; check_model();
      chk("byp_01", 32'(out2), 32'h1);
      edt_bypass = 1'b0; #1; check_model();
      chk("byp_off", 32'(out2), 32'h3);

      // mid-operation reset between edges
      shift_en = 1'b1; edt_update = 1'b1; pipe_in = 2'b10; step();
      edt_update = 1'b0;
      step(); step(); step();
      chk("mid_cnt4", 32'(cnt4), 32'h3);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_model();
      chk("mid_out4", 32'(out4), 32'h0);
      #1 rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         pipe_in    = 2'($urandom);
         chan_mask  = 2'($urandom);
         shift_en   = ($urandom_range(0, 3) != 0);
         edt_update = ($urandom_range(0, 11) == 0);
         edt_bypass = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 60) == 0) begin
            #2 rst_n = 1'b0;
            #1 model_reset();
            check_model();
            #1 rst_n = 1'b1;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
